smc_fan_tach_meas: RTL and testbench

//  Measures the blower-cabinet fan tachometers ahead of the SMC monitor register file.

---
 rtl/smc_fan_tach_meas.sv | 205 ++++++++++++++++++++
 tb/tb_smc_fan_tach_meas.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/smc_fan_tach_meas.sv
// -----------------------------------------------------------------------------
// smc_fan_tach_meas
//
// Measures the two blower-cabinet fan tachometers for the SMC monitor register
// file. Each channel is synchronised, glitch-filtered and rising-edge counted
// over a fixed gate window. At the end of every window the counts are loaded
// into the result registers, unless the 8051 is in the middle of a multi-byte
// read (I_freeze). Stall detection runs every window regardless of I_freeze.
//
// Ports
//   I_clk          system clock
//   I_reset        synchronous, active-high reset
//   I_fan0_tach    raw FAN0 tach (asynchronous)
//   I_fan1_tach    raw FAN1 tach (asynchronous)
//   I_freeze       blocks result update while high at window end
//   O_fan0_count   FAN0 rising edges in the last accepted window
//   O_fan1_count   FAN1 rising edges in the last accepted window
//   O_fan0_stall   FAN0 stalled
//   O_fan1_stall   FAN1 stalled
//   O_fan_fault    registered OR of the stall flags
//   O_valid        one-cycle pulse when new counts were loaded
// -----------------------------------------------------------------------------
module smc_fan_tach_meas #(
   parameter int PRESCALE_DIV  = 1000,
   parameter int GATE_TICKS    = 1000,
   parameter int CNT_W         = 16,
   parameter int SYNC_STAGES   = 2,
   parameter int FILT_LEN      = 4,
   parameter int STALL_WINDOWS = 2
) (
   input  logic             I_clk,
   input  logic             I_reset,
   input  logic             I_fan0_tach,
   input  logic             I_fan1_tach,
   input  logic             I_freeze,
   output logic [CNT_W-1:0] O_fan0_count,
   output logic [CNT_W-1:0] O_fan1_count,
   output logic             O_fan0_stall,
   output logic             O_fan1_stall,
   output logic             O_fan_fault,
   output logic             O_valid
);

   localparam int PRESC_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
   localparam int WIN_W   = (GATE_TICKS > 1) ? $clog2(GATE_TICKS) : 1;
   localparam int FILT_W  = $clog2(FILT_LEN + 1);
   localparam int ZW_W    = $clog2(STALL_WINDOWS + 1);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE_DIV - 1);
   localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(GATE_TICKS - 1);
   localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(FILT_LEN - 1);
   localparam logic [ZW_W-1:0]    ZW_SAT     = ZW_W'(STALL_WINDOWS);
   localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

   // --------------------------------------------------------------------------
   // Gate timing: prescaler and window counter
   // --------------------------------------------------------------------------
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [WIN_W-1:0]   win_q, win_d;
   logic               tick;
   logic               win_end;

   always_comb begin
      tick    = (presc_q == PRESC_LAST);
      win_end = tick && (win_q == WIN_LAST);
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
      win_d   = win_q;
      if (tick) begin
         win_d = (win_q == WIN_LAST) ? '0 : win_q + WIN_W'(1);
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         presc_q <= '0;
         win_q   <= '0;
      end else begin
         presc_q <= presc_d;
         win_q   <= win_d;
      end
   end

   // --------------------------------------------------------------------------
   // Per-channel measurement
   // --------------------------------------------------------------------------
   logic [CNT_W-1:0] res_w   [2];
   logic             stall_w [2];

   for (genvar ch = 0; ch < 2; ch++) begin : g_ch
      logic                   tach_raw;
      logic                   samp;
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [FILT_W-1:0]      filt_cnt_q, filt_cnt_d;
      logic                   filt_lvl_q, filt_lvl_d;
      logic                   filt_prev_q, filt_prev_d;
      logic                   rise;
      logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
      logic [CNT_W-1:0]       res_q, res_d;
      logic [ZW_W-1:0]        zwin_q, zwin_d;
      logic                   stall_q, stall_d;

      assign tach_raw = (ch == 0) ? I_fan0_tach : I_fan1_tach;

      always_comb begin
         sync_d = {sync_q[SYNC_STAGES-2:0], tach_raw};
         samp   = sync_q[SYNC_STAGES-1];

         // Run-length filter: the level only follows the input after
         // FILT_LEN consecutive samples that disagree with it.
         filt_lvl_d = filt_lvl_q;
         filt_cnt_d = '0;
         if (samp != filt_lvl_q) begin
            if (filt_cnt_q == FILT_LAST) begin
               filt_lvl_d = samp;
            end else begin
               filt_cnt_d = filt_cnt_q + FILT_W'(1);
            end
         end

         filt_prev_d = filt_lvl_q;
         rise        = filt_lvl_q & ~filt_prev_q;

         // An edge arriving on the window-end cycle seeds the next window
         // so it is neither dropped nor counted twice.
         edge_cnt_d = edge_cnt_q;
         if (win_end) begin
            edge_cnt_d = {{(CNT_W-1){1'b0}}, rise};
         end else if (rise && (edge_cnt_q != CNT_MAX)) begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
         end

         res_d = res_q;
         if (win_end && !I_freeze) begin
            res_d = edge_cnt_q;
         end

         // Stall tracking sees every window, frozen or not.
         zwin_d  = zwin_q;
         stall_d = stall_q;
         if (win_end) begin
            if (edge_cnt_q == '0) begin
               zwin_d  = (zwin_q == ZW_SAT) ? zwin_q : zwin_q + ZW_W'(1);
               stall_d = (zwin_d == ZW_SAT);
            end else begin
               zwin_d  = '0;
               stall_d = 1'b0;
            end
         end
      end

      always_ff @(posedge I_clk) begin
         if (I_reset) begin
            sync_q      <= '0;
            filt_cnt_q  <= '0;
            filt_lvl_q  <= 1'b0;
            filt_prev_q <= 1'b0;
            edge_cnt_q  <= '0;
            res_q       <= '0;
            zwin_q      <= '0;
            stall_q     <= 1'b0;
         end else begin
            sync_q      <= sync_d;
            filt_cnt_q  <= filt_cnt_d;
            filt_lvl_q  <= filt_lvl_d;
            filt_prev_q <= filt_prev_d;
            edge_cnt_q  <= edge_cnt_d;
            res_q       <= res_d;
            zwin_q      <= zwin_d;
            stall_q     <= stall_d;
         end
      end

      assign res_w[ch]   = res_q;
      assign stall_w[ch] = stall_q;
   end

   // --------------------------------------------------------------------------
   // Shared status
   // --------------------------------------------------------------------------
   logic valid_q, valid_d;
   logic fault_q, fault_d;

   always_comb begin
      valid_d = win_end && !I_freeze;
      fault_d = stall_w[0] | stall_w[1];
   end

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

   assign O_fan0_count = res_w[0];
   assign O_fan1_count = res_w[1];
   assign O_fan0_stall = stall_w[0];
   assign O_fan1_stall = stall_w[1];
   assign O_fan_fault  = fault_q;
   assign O_valid      = valid_q;

endmodule

// File: tb/tb_smc_fan_tach_meas.sv
module tb_smc_fan_tach_meas;

   localparam int K_ZERO  = 0;
   localparam int K_WAVE8 = 1;
   localparam int K_G16   = 2;
   localparam int K_P10   = 3;
   localparam int K_P2    = 4;
   localparam int K_EA    = 5;
   localparam int K_EB    = 6;
   localparam int K_F1P   = 7;

   typedef struct {
      int c0;
      int c1;
      int s0;
      int s1;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst2 = 1'b1;
   logic fan0 = 1'b0;
   logic fan1 = 1'b0;
   logic frz = 1'b0;
   logic fan2 = 1'b0;
   logic fan3 = 1'b0;
   logic frz2 = 1'b0;

   logic [3:0] c0, c1, c0_2, c1_2;
   logic       st0, st1, flt, vld;
   logic       st0_2, st1_2, flt_2, vld_2;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];
   int   exp2_q[$];

   always #5 clk = ~clk;

   smc_fan_tach_meas #(
      .PRESCALE_DIV(4), .GATE_TICKS(8), .CNT_W(4),
      .SYNC_STAGES(2), .FILT_LEN(4), .STALL_WINDOWS(2)
   ) dut (
      .I_clk(clk), .I_reset(rst), .I_fan0_tach(fan0), .I_fan1_tach(fan1),
      .I_freeze(frz), .O_fan0_count(c0), .O_fan1_count(c1),
      .O_fan0_stall(st0), .O_fan1_stall(st1), .O_fan_fault(flt), .O_valid(vld)
   );

   // Saturation instance: FILT_LEN=1 lets a 2-clk wave through.
   smc_fan_tach_meas #(
      .PRESCALE_DIV(4), .GATE_TICKS(8), .CNT_W(4),
      .SYNC_STAGES(2), .FILT_LEN(1), .STALL_WINDOWS(2)
   ) dut_sat (
      .I_clk(clk), .I_reset(rst2), .I_fan0_tach(fan2), .I_fan1_tach(fan3),
      .I_freeze(frz2), .O_fan0_count(c0_2), .O_fan1_count(c1_2),
      .O_fan0_stall(st0_2), .O_fan1_stall(st1_2), .O_fan_fault(flt_2), .O_valid(vld_2)
   );

   task automatic chk(input string name, input int act, input int expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic logic pat(input int kind, input int j);
      case (kind)
         K_WAVE8: return ((j % 8) < 4);
         K_G16:   return ((j % 16) < 8) || ((j % 16) == 10) || ((j % 16) == 11);
         K_P10:   return ((j % 10) < 5) && (j < 28);
         K_P2:    return ((j % 2) == 0) && (j < 28);
         K_EA:    return (j < 4) || (j >= 25);
         K_EB:    return (j < 4);
         K_F1P:   return ((j >= 2) && (j <= 4)) || ((j >= 12) && (j <= 15));
         default: return 1'b0;
      endcase
   endfunction

   task automatic push(input int e0, input int e1, input int s0, input int s1);
      exp_t e;
      e.c0 = e0; e.c1 = e1; e.s0 = s0; e.s1 = s1;
      exp_q.push_back(e);
   endtask

   // Drives one gate window (or part of one). Called #1 after the edge that
   // starts the window; returns the offset of the edge after which O_valid was
   // first seen, or -1.
   task automatic run_window(input int k0, input int k1, input int ncyc,
                             input bit freeze_end, output int valid_at);
      valid_at = -1;
      for (int j = 0; j < ncyc; j++) begin
         fan0 = pat(k0, j);
         fan1 = pat(k1, j);
         frz  = freeze_end && (j >= 16);
         @(posedge clk);
         #1;
         if (vld && (valid_at < 0)) valid_at = j + 1;
      end
      frz = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cnt0"},  int'(c0),  0);
      chk({tag, "_cnt1"},  int'(c1),  0);
      chk({tag, "_stall0"}, int'(st0), 0);
      chk({tag, "_stall1"}, int'(st1), 0);
      chk({tag, "_fault"}, int'(flt), 0);
      chk({tag, "_valid"}, int'(vld), 0);
   endtask

   // Scoreboard monitor for the main instance.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (vld === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("sb_cnt0",   int'(c0),  e.c0);
               chk("sb_cnt1",   int'(c1),  e.c1);
               chk("sb_stall0", int'(st0), e.s0);
               chk("sb_stall1", int'(st1), e.s1);
               @(negedge clk);
               chk("sb_fault", int'(flt), (e.s0 | e.s1));
            end
         end
      end
   end

   // Stimulus for the saturation instance: toggle every cycle.
   initial begin
      wait (rst2 == 1'b0);
      fan2 = 1'b1;
      forever begin
         @(posedge clk);
         #1 fan2 = ~fan2;
      end
   end

   // Monitor for the saturation instance, bounded waits.
   initial begin
      int t;
      wait (rst2 == 1'b0);
      for (int i = 0; i < 4; i++) begin
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while ((vld_2 !== 1'b1) && (t < 40));
         if (vld_2 !== 1'b1) begin
            chk("sat_valid_timeout", t, -1);
         end else if (exp2_q.size() == 0) begin
            chk("sat_unexpected_valid", 1, 0);
         end else begin
            chk("sat_cnt0", int'(c0_2), exp2_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
      $fatal(1);
   end

   initial begin
      int va;

      // 15 edges saturates CNT_W=4; window 0 only sees 14 of the 16 edges
      // because of the 4-cycle pipeline latency at FILT_LEN=1.
      exp2_q.push_back(14);
      exp2_q.push_back(15);
      exp2_q.push_back(15);
      exp2_q.push_back(15);

      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst  = 1'b0;
      rst2 = 1'b0;

      // 8-clk wave on FAN0, FAN1 idle: stall after the second window.
      push(4, 0, 0, 0); run_window(K_WAVE8, K_ZERO, 32, 1'b0, va);
      push(4, 0, 0, 1); run_window(K_WAVE8, K_ZERO, 32, 1'b0, va);

      // FAN0 16-clk wave with 2-clk glitches in its low phase (2 real edges);
      // FAN1 gets a 3-clk pulse (rejected) and a 4-clk pulse (counted).
      push(2, 1, 0, 0); run_window(K_G16, K_F1P, 32, 1'b0, va);
      push(4, 0, 0, 0); run_window(K_WAVE8, K_ZERO, 32, 1'b0, va);

      // 10-clk wave: 3 edges in the window.
      push(3, 0, 0, 1); run_window(K_P10, K_ZERO, 32, 1'b0, va);

      // 2-clk wave suppressed by the filter, under freeze: no load.
      run_window(K_P2, K_ZERO, 32, 1'b1, va);
      chk("freeze_no_valid", va, -1);
      chk("freeze_hold_cnt0", int'(c0), 3);
      chk("freeze_hold_cnt1", int'(c1), 0);
      chk("freeze_stall0", int'(st0), 0);
      chk("freeze_stall1", int'(st1), 1);

      // Second zero window counts the frozen one: FAN0 stalls now.
      push(0, 0, 1, 1); run_window(K_P2, K_ZERO, 32, 1'b0, va);
      chk("post_freeze_valid_at", va, 32);
      push(4, 0, 0, 1); run_window(K_WAVE8, K_ZERO, 32, 1'b0, va);

      // Edge on win_end goes to the following window.
      push(1, 0, 0, 1); run_window(K_EA, K_ZERO, 32, 1'b0, va);
      push(1, 0, 0, 1); run_window(K_EB, K_ZERO, 32, 1'b0, va);

      // Reset mid-window with FAN1 stalled.
      run_window(K_WAVE8, K_ZERO, 10, 1'b0, va);
      chk("pre_reset_stall1", int'(st1), 1);
      chk("pre_reset_fault", int'(flt), 1);
      fan0 = 1'b0;
      rst  = 1'b1;
      @(posedge clk);
      #1;
      chk_all_zero("midreset");
      rst = 1'b0;
      push(4, 0, 0, 0); run_window(K_WAVE8, K_ZERO, 32, 1'b0, va);
      chk("reset_first_valid_at", va, 32);
      push(4, 0, 0, 1); run_window(K_WAVE8, K_ZERO, 32, 1'b0, va);

      repeat (4) @(posedge clk);
      #1;
      chk("sb_drained", exp_q.size(), 0);
      chk("sat_drained", exp2_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
